// File: rtl/bandai_bus_arb.sv
// Cartridge bus arbiter: shares one mapper bus between the console and a
// programmer port. Console cycles pass straight through in IDLE/HOST. A
// programmer cycle is a registered setup/strobe/hold/release sequence, and a
// starvation counter guarantees the programmer eventually wins.
module bandai_bus_arb #(
  parameter int STRB_CYC   = 2,
  parameter int STARVE_MAX = 64
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       H_CEn,
  input  logic       H_OEn,
  input  logic       H_WEn,
  input  logic [7:0] H_ADDR,
  output logic       H_WAITn,
  input  logic       P_REQ,
  input  logic       P_WR,
  input  logic [7:0] P_ADDR,
  input  logic [7:0] P_WDATA,
  output logic       P_ACK,
  output logic [7:0] P_RDATA,
  output logic       M_CEn,
  output logic       M_OEn,
  output logic       M_WEn,
  output logic [7:0] M_ADDR,
  output logic [7:0] M_DQ_O,
  output logic       M_DQ_OE,
  input  logic [7:0] M_DQ_I,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    IDLE,
    HOST,
    P_SETUP,
    P_STROBE,
    P_HOLD,
    P_REL
  } state_t;

  localparam logic [3:0] STRB_LAST  = 4'(STRB_CYC - 1);
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  state_t     state_q, state_d;
  logic [3:0] strb_cnt_q, strb_cnt_d;
  logic [7:0] starve_cnt_q, starve_cnt_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       wr_q, wr_d;
  logic [7:0] rdata_q, rdata_d;
  logic       m_cen_q, m_cen_d;
  logic       m_oen_q, m_oen_d;
  logic       m_wen_q, m_wen_d;
  logic       m_dq_oe_q, m_dq_oe_d;
  logic       p_ack_q, p_ack_d;
  logic       busy_q, busy_d;

  logic starve_full;
  logic pass_through;

  assign starve_full  = (starve_cnt_q == STARVE_LIM);
  assign pass_through = (state_q == IDLE) || (state_q == HOST);

  // Next-state, programmer latches, strobe timer and starvation counter.
  always_comb begin
    state_d      = state_q;
    strb_cnt_d   = strb_cnt_q;
    starve_cnt_d = starve_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_d         = wr_q;
    rdata_d      = rdata_q;

    case (state_q)
      IDLE: begin
        // Console normally wins a tie; a starved programmer takes the bus.
        if (P_REQ && (H_CEn || starve_full)) begin
          state_d      = P_SETUP;
          addr_d       = P_ADDR;
          wdata_d      = P_WDATA;
          wr_d         = P_WR;
          starve_cnt_d = 8'd0;
        end else if (!H_CEn) begin
          state_d = HOST;
        end
      end
      HOST: begin
        if (H_CEn) state_d = IDLE;
      end
      P_SETUP: begin
        state_d    = P_STROBE;
        strb_cnt_d = STRB_LAST;
      end
      P_STROBE: begin
        if (strb_cnt_q == 4'd0) begin
          state_d = P_HOLD;
          // Read data is sampled on the final strobe edge, while OEn is low.
          if (!wr_q) rdata_d = M_DQ_I;
        end else begin
          strb_cnt_d = strb_cnt_q - 4'd1;
        end
      end
      P_HOLD:  state_d = P_REL;
      P_REL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A waiting programmer accumulates starvation credit until granted.
    if (pass_through && P_REQ && (state_d != P_SETUP) && !starve_full) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
  end

  // Registered mapper strobes and status, decoded from the state being entered.
  always_comb begin
    m_cen_d   = !((state_d == P_SETUP) || (state_d == P_STROBE) || (state_d == P_HOLD));
    m_oen_d   = !((state_d == P_STROBE) && !wr_d);
    m_wen_d   = !((state_d == P_STROBE) && wr_d);
    m_dq_oe_d = wr_d && ((state_d == P_SETUP) || (state_d == P_STROBE) || (state_d == P_HOLD));
    p_ack_d   = (state_d == P_REL);
    busy_d    = (state_d != IDLE);
  end

  // FSM and all registered state; reset returns the bus to an idle, released condition.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= IDLE;
      strb_cnt_q   <= 4'd0;
      starve_cnt_q <= 8'd0;
      addr_q       <= 8'd0;
      wdata_q      <= 8'd0;
      wr_q         <= 1'b0;
      rdata_q      <= 8'd0;
      m_cen_q      <= 1'b1;
      m_oen_q      <= 1'b1;
      m_wen_q      <= 1'b1;
      m_dq_oe_q    <= 1'b0;
      p_ack_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      strb_cnt_q   <= strb_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wr_q         <= wr_d;
      rdata_q      <= rdata_d;
      m_cen_q      <= m_cen_d;
      m_oen_q      <= m_oen_d;
      m_wen_q      <= m_wen_d;
      m_dq_oe_q    <= m_dq_oe_d;
      p_ack_q      <= p_ack_d;
      busy_q       <= busy_d;
    end
  end

  // Mapper bus mux: console passthrough when idle/host, registered programmer
  // drive otherwise; reset overrides everything so the mapper is released at once.
  always_comb begin
    M_CEn   = m_cen_q;
    M_OEn   = m_oen_q;
    M_WEn   = m_wen_q;
    M_ADDR  = addr_q;
    M_DQ_OE = m_dq_oe_q;
    if (pass_through) begin
      M_CEn   = H_CEn;
      M_OEn   = H_OEn;
      M_WEn   = H_WEn;
      M_ADDR  = H_ADDR;
      M_DQ_OE = 1'b0;
    end
    if (!RSTn) begin
      M_CEn   = 1'b1;
      M_OEn   = 1'b1;
      M_WEn   = 1'b1;
      M_ADDR  = 8'd0;
      M_DQ_OE = 1'b0;
    end
  end

  assign M_DQ_O  = wdata_q;
  assign P_RDATA = rdata_q;
  assign P_ACK   = p_ack_q;
  assign BUSY    = busy_q;
  // Console is stalled only while it asks for the bus during a programmer cycle.
  assign H_WAITn = !(!H_CEn && !pass_through);

endmodule

// File: doc/bandai_bus_arb.md
BANDAI_BUS_ARB -- requirements
Module: bandai_bus_arb

Interface
REQ-001 The block SHALL have one clock, CLK, and an asynchronous, active-low reset, RSTn.
REQ-002 The block SHALL take the following parameters (name, default, meaning):
- STRB_CYC, 2, strobe width in CLK cycles, legal 1..15.
- STARVE_MAX, 64, count of programmer wait cycles after which the programmer wins the next grant, legal 1..255.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- CLK, in, 1, clock.
- RSTn, in, 1, asynchronous active-low reset.
- H_CEn, H_OEn, H_WEn, in, 1 each, console cartridge strobes.
- H_ADDR, in, 8, console address lines.
- H_WAITn, out, 1, console wait, active low.
- P_REQ, in, 1, programmer request.
- P_WR, in, 1, programmer cycle type: 1 = write, 0 = read.
- P_ADDR, in, 8, programmer address.
- P_WDATA, in, 8, programmer write data.
- P_ACK, out, 1, programmer completion pulse.
- P_RDATA, out, 8, programmer read data.
- M_CEn, M_OEn, M_WEn, out, 1 each, strobes to the mapper.
- M_ADDR, out, 8, address to the mapper.
- M_DQ_O, out, 8, write data to the mapper.
- M_DQ_OE, out, 1, output enable for M_DQ_O.
- M_DQ_I, in, 8, read data from the mapper.
- BUSY, out, 1, asserted high whenever the FSM is not in IDLE.

Function
REQ-004 The FSM SHALL have the states IDLE, HOST, P_SETUP, P_STROBE, P_HOLD and P_REL.
REQ-005 In IDLE and HOST, M_CEn, M_OEn, M_WEn and M_ADDR SHALL follow the matching H_* inputs combinationally, with M_DQ_OE = 0.
REQ-006 In IDLE, H_CEn = 0 SHALL cause a transition to HOST, unless the condition in REQ-008 holds.
REQ-007 In IDLE, P_REQ = 1 with H_CEn = 1 SHALL cause a transition to P_SETUP, latching P_ADDR, P_WR and P_WDATA on that edge.
REQ-008 If H_CEn = 0 and P_REQ = 1 in the same IDLE cycle:
- the host SHALL win;
- exception: when starve_cnt == STARVE_MAX, the programmer SHALL win.
REQ-009 HOST SHALL return to IDLE on the first CLK edge at which H_CEn = 1.
REQ-010 starve_cnt (8 bits) SHALL increment each cycle that P_REQ = 1 and the FSM is in HOST or IDLE without a grant, SHALL saturate at STARVE_MAX, and SHALL clear on entry to P_SETUP.
REQ-011 P_SETUP SHALL last 1 cycle with:
- M_CEn = 0, M_OEn = 1, M_WEn = 1;
- M_ADDR = latched address;
- M_DQ_OE = latched P_WR;
- M_DQ_O = latched data.
REQ-012 P_STROBE SHALL last exactly STRB_CYC cycles, with M_WEn = 0 for a write or M_OEn = 0 for a read; all other M_* signals hold.
REQ-013 For a read, P_RDATA SHALL capture M_DQ_I on the last P_STROBE edge and hold it until the next read completes.
REQ-014 P_HOLD SHALL last 1 cycle with M_WEn = M_OEn = 1, M_CEn = 0, and address and data held, so the mapper's rising-WEn latch sees stable address and data.
REQ-015 P_REL SHALL last 1 cycle with:
- M_CEn = 1, M_DQ_OE = 0;
- P_ACK = 1 for exactly this cycle;
- next state IDLE.
REQ-016 Programmer latency from the grant edge to P_ACK SHALL be STRB_CYC + 3 cycles (5 at the default).
REQ-017 Deassertion of P_REQ after the grant SHALL NOT abort the cycle; the cycle completes and P_ACK still pulses.
REQ-018 H_WAITn SHALL be 0 whenever H_CEn = 0 while the FSM is in P_SETUP..P_REL, and 1 otherwise.
REQ-019 A held console cycle SHALL enter HOST from IDLE on the edge after P_REL.
REQ-020 P_REQ still high in the P_REL cycle SHALL be treated as a new request only from IDLE, so back-to-back programmer cycles have at least one IDLE cycle between them.
REQ-021 All outputs in the P_* states SHALL be registered; only the IDLE/HOST passthrough may be combinational.

Reset
REQ-022 RSTn = 0 SHALL, asynchronously and even mid-cycle:
- force the FSM to IDLE;
- drive M_CEn, M_OEn, M_WEn to 1;
- drive M_DQ_OE, P_ACK, BUSY to 0;
- drive H_WAITn to 1;
- clear P_RDATA, M_ADDR, M_DQ_O and starve_cnt to 0.
REQ-023 After RSTn rises, the first grant SHALL be decided on the first CLK edge.

Verification
REQ-024 Programmer write: P_REQ=1, P_WR=1, P_ADDR=C2h, P_WDATA=15h, console idle -> M_CEn low for 4 cycles, M_WEn low for 2, M_DQ_O=15h, P_ACK on cycle 5.
REQ-025 Programmer read: P_ADDR=C1h, M_DQ_I=3Ah -> P_RDATA=3Ah at P_ACK, M_OEn low for 2 cycles, M_DQ_OE=0 throughout.
REQ-026 Simultaneous request: H_CEn=0 and P_REQ=1 in the same IDLE cycle with starve_cnt=0 -> HOST granted, M_ADDR follows H_ADDR, P_ACK deferred.
REQ-027 Starvation: continuous console traffic with P_REQ=1 -> programmer granted at the first IDLE after 64 wait cycles even with H_CEn=0; H_WAITn=0 until P_REL.
REQ-028 Reset during P_STROBE of a write -> M_WEn=1, M_CEn=1, M_DQ_OE=0 immediately, no P_ACK, BUSY=0.
REQ-029 STRB_CYC=1 build -> grant-to-P_ACK latency of 4 cycles.
